// File: rtl/mac_stop_pkg.sv
// Shared types and width helpers for the MAC accumulation / write-back stage.
package mac_stop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_M  = 2;
  localparam int unsigned DEF_K  = 2;
  localparam int unsigned DEF_N  = 2;
  localparam int unsigned DEF_DW = 32;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned res_w(input int unsigned dw, input int unsigned k);
    return 2 * dw + $clog2(k);
  endfunction

  localparam int unsigned DEF_ROW_W = idx_w(DEF_M);
  localparam int unsigned DEF_K_W   = idx_w(DEF_K);
  localparam int unsigned DEF_COL_W = idx_w(DEF_N);

endpackage

// File: rtl/mac_stop_acc_reg.sv
// Running-sum register plus the captured final sum that drives result_data.
module mac_stop_acc_reg
  import mac_stop_pkg::*;
#(
  parameter int unsigned PW = 64,
  parameter int unsigned RW = 65
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [PW-1:0] product,
  input  logic          load,
  input  logic          add,
  input  logic          clear,
  input  logic          fin,
  output logic [RW-1:0] acc,
  output logic [RW-1:0] sum
);

  logic [RW-1:0] prod_ext;
  logic [RW-1:0] acc_d, acc_q;
  logic [RW-1:0] sum_d, sum_q;

  // Next accumulator / final-sum values; fin both captures the sum and empties acc.
  always_comb begin
    prod_ext = RW'(product);
    acc_d    = acc_q;
    sum_d    = sum_q;
    if (fin) begin
      sum_d = acc_q + prod_ext;
      acc_d = '0;
    end else if (clear) begin
      acc_d = '0;
    end else if (load) begin
      acc_d = prod_ext;
    end else if (add) begin
      acc_d = acc_q + prod_ext;
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign acc = acc_q;
  assign sum = sum_q;

endmodule

// File: rtl/mac_stop_accum.sv
// Sums K tagged products per C element, writes it back, flags done and k-order errors.
module mac_stop_accum
  import mac_stop_pkg::*;
#(
  parameter int unsigned M                        = DEF_M,
  parameter int unsigned K                        = DEF_K,
  parameter int unsigned N                        = DEF_N,
  parameter int unsigned DATA_WIDTH_INIT_MATRIX   = DEF_DW,
  parameter int unsigned DATA_WIDTH_RESULT_MATRIX = res_w(DATA_WIDTH_INIT_MATRIX, K)
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [2*DATA_WIDTH_INIT_MATRIX-1:0] product_in,
  input  logic                                product_valid,
  input  logic [idx_w(M)-1:0]                 row_idx,
  input  logic [idx_w(K)-1:0]                 k_idx,
  input  logic [idx_w(N)-1:0]                 col_idx,
  input  logic                                clear_done,
  output logic                                result_we,
  output logic [idx_w(M)-1:0]                 result_row_addr,
  output logic [idx_w(N)-1:0]                 result_col_addr,
  output logic [DATA_WIDTH_RESULT_MATRIX-1:0] result_data,
  output logic                                accum_done,
  output logic                                seq_err,
  output logic [$clog2(M*N+1)-1:0]            elems_written
);

  localparam int unsigned RW_W = idx_w(M);
  localparam int unsigned K_W  = idx_w(K);
  localparam int unsigned CL_W = idx_w(N);
  localparam int unsigned EL_W = $clog2(M*N+1);
  localparam logic [RW_W-1:0] ROW_LAST = RW_W'(M - 1);
  localparam logic [K_W-1:0]  K_LAST   = K_W'(K - 1);
  localparam logic [CL_W-1:0] COL_LAST = CL_W'(N - 1);

  state_e            state_d, state_q;
  logic [K_W-1:0]    expk_d, expk_q;
  logic              err_d, err_q;
  logic [EL_W-1:0]   elems_d, elems_q;
  logic              we_d, we_q;
  logic [RW_W-1:0]   row_d, row_q;
  logic [CL_W-1:0]   col_d, col_q;
  logic              acc_load, acc_add, acc_clear, acc_fin;
  logic [DATA_WIDTH_RESULT_MATRIX-1:0] acc_val;

  // Next-state, k-sequence check and write-port control.
  always_comb begin
    state_d   = state_q;
    expk_d    = expk_q;
    err_d     = err_q;
    elems_d   = elems_q;
    we_d      = 1'b0;
    row_d     = row_q;
    col_d     = col_q;
    acc_load  = 1'b0;
    acc_add   = 1'b0;
    acc_clear = 1'b0;
    acc_fin   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (product_valid && (k_idx == '0)) begin
          acc_load = 1'b1;
          expk_d   = K_W'(1);
          state_d  = ST_ACC;
        end else if (product_valid) begin
          err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (product_valid && (k_idx == expk_q) && (k_idx == K_LAST)) begin
          acc_fin = 1'b1;
          we_d    = 1'b1;
          row_d   = row_idx;
          col_d   = col_idx;
          expk_d  = '0;
          elems_d = elems_q + EL_W'(1);
          if ((row_idx == ROW_LAST) && (col_idx == COL_LAST)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACC;
          end
        end else if (product_valid && (k_idx == expk_q)) begin
          acc_add = 1'b1;
          expk_d  = expk_q + K_W'(1);
        end else if (product_valid) begin
          // Out-of-order k: drop the element, restart cleanly on a fresh k=0.
          err_d = 1'b1;
          if (k_idx == '0) begin
            acc_load = 1'b1;
            expk_d   = K_W'(1);
          end else begin
            acc_clear = 1'b1;
            expk_d    = '0;
          end
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_DONE: begin
        if (clear_done) begin
          state_d = ST_IDLE;
          elems_d = '0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and write-port registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      expk_q  <= '0;
      err_q   <= 1'b0;
      elems_q <= '0;
      we_q    <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      expk_q  <= expk_d;
      err_q   <= err_d;
      elems_q <= elems_d;
      we_q    <= we_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  mac_stop_acc_reg #(
    .PW (2*DATA_WIDTH_INIT_MATRIX),
    .RW (DATA_WIDTH_RESULT_MATRIX)
  ) u_acc (
    .clk     (clk),
    .resetn  (resetn),
    .product (product_in),
    .load    (acc_load),
    .add     (acc_add),
    .clear   (acc_clear),
    .fin     (acc_fin),
    .acc     (acc_val),
    .sum     (result_data)
  );

  assign result_we       = we_q;
  assign result_row_addr = row_q;
  assign result_col_addr = col_q;
  assign accum_done      = (state_q == ST_DONE);
  assign seq_err         = err_q;
  assign elems_written   = elems_q;

endmodule

// File: tb/tb_mac_stop_accum.sv
// Directed, table-driven bench for mac_stop_accum with M=K=N=2, DW=8.
module tb_mac_stop_accum;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] product_in = 16'd0;
  logic        product_valid = 1'b0;
  logic        row_idx = 1'b0;
  logic        k_idx = 1'b0;
  logic        col_idx = 1'b0;
  logic        clear_done = 1'b0;
  logic        result_we;
  logic        result_row_addr;
  logic        result_col_addr;
  logic [16:0] result_data;
  logic        accum_done;
  logic        seq_err;
  logic [2:0]  elems_written;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mac_stop_accum #(
    .M (2), .K (2), .N (2), .DATA_WIDTH_INIT_MATRIX (8)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .product_in      (product_in),
    .product_valid   (product_valid),
    .row_idx         (row_idx),
    .k_idx           (k_idx),
    .col_idx         (col_idx),
    .clear_done      (clear_done),
    .result_we       (result_we),
    .result_row_addr (result_row_addr),
    .result_col_addr (result_col_addr),
    .result_data     (result_data),
    .accum_done      (accum_done),
    .seq_err         (seq_err),
    .elems_written   (elems_written)
  );

  typedef struct {
    logic        v;
    logic        r;
    logic        k;
    logic        c;
    logic [15:0] p;
    logic        clr;
    logic        we;
    logic        er;
    logic        ec;
    logic [16:0] ed;
    logic        edone;
    logic        eerr;
    logic [2:0]  eel;
  } vec_t;

  vec_t vec [14];

  // Packed {we,row,col,data,done,err,elems} for one-shot comparison.
  function automatic logic [24:0] pack(input logic we, input logic r, input logic c,
                                       input logic [16:0] d, input logic dn,
                                       input logic er, input logic [2:0] el);
    return {we, r, c, d, dn, er, el};
  endfunction

  task automatic chk(input string name, input logic [24:0] exp_v);
    logic [24:0] act;
    act = pack(result_we, result_row_addr, result_col_addr, result_data,
               accum_done, seq_err, elems_written);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got {we,row,col,data,done,err,elems}=%h, want %h", name, act, exp_v);
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic k, input logic c,
                       input logic [15:0] p, input logic clr);
    product_valid = v;
    row_idx       = r;
    k_idx         = k;
    col_idx       = c;
    product_in    = p;
    clear_done    = clr;
    @(posedge clk);
    #1;
    product_valid = 1'b0;
    clear_done    = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    product_valid = 1'b0;
    clear_done = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] prods [8];
  logic [16:0] sums [4];

  initial begin
    prods = '{16'd5, 16'd14, 16'd6, 16'd16, 16'd15, 16'd28, 16'd18, 16'd32};
    sums  = '{17'd19, 17'd22, 17'd43, 17'd50};

    //            v     r     k     c     p       clr   we    er    ec    data     done  err   elems
    vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd5,  1'b0, 1'b0, 1'b0, 1'b0, 17'd0,  1'b0, 1'b0, 3'd0};
    vec[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd14, 1'b0, 1'b1, 1'b0, 1'b0, 17'd19, 1'b0, 1'b0, 3'd1};
    vec[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd6,  1'b0, 1'b0, 1'b0, 1'b0, 17'd19, 1'b0, 1'b0, 3'd1};
    vec[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd16, 1'b0, 1'b1, 1'b0, 1'b1, 17'd22, 1'b0, 1'b0, 3'd2};
    vec[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd15, 1'b0, 1'b0, 1'b0, 1'b1, 17'd22, 1'b0, 1'b0, 3'd2};
    vec[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'd28, 1'b0, 1'b1, 1'b1, 1'b0, 17'd43, 1'b0, 1'b0, 3'd3};
    vec[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd18, 1'b0, 1'b0, 1'b1, 1'b0, 17'd43, 1'b0, 1'b0, 3'd3};
    vec[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd32, 1'b0, 1'b1, 1'b1, 1'b1, 17'd50, 1'b1, 1'b0, 3'd4};
    vec[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  1'b0, 1'b0, 1'b1, 1'b1, 17'd50, 1'b1, 1'b0, 3'd4};
    vec[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd5,  1'b0, 1'b0, 1'b1, 1'b1, 17'd50, 1'b1, 1'b0, 3'd4};
    vec[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd14, 1'b0, 1'b0, 1'b1, 1'b1, 17'd50, 1'b1, 1'b0, 3'd4};
    vec[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 1'b1, 1'b1, 17'd50, 1'b0, 1'b0, 3'd0};
    vec[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd5,  1'b0, 1'b0, 1'b1, 1'b1, 17'd50, 1'b0, 1'b0, 3'd0};
    vec[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd14, 1'b0, 1'b1, 1'b0, 1'b0, 17'd19, 1'b0, 1'b0, 3'd1};

    // Reset state, checked while resetn is asserted.
    #2;
    chk("reset_state", 25'd0);
    do_reset();
    chk("post_reset_idle", 25'd0);

    // Back-to-back stream, DONE handling, clear_done and restart.
    for (int i = 0; i < 14; i++) begin
      drive(vec[i].v, vec[i].r, vec[i].k, vec[i].c, vec[i].p, vec[i].clr);
      chk($sformatf("vec%0d", i),
          pack(vec[i].we, vec[i].er, vec[i].ec, vec[i].ed, vec[i].edone, vec[i].eerr, vec[i].eel));
    end

    // Same stream with three idle cycles after every product.
    do_reset();
    for (int e = 0; e < 4; e++) begin
      for (int k = 0; k < 2; k++) begin
        logic [1:0] rc;
        logic [16:0] last_d;
        logic [1:0]  last_rc;
        logic [2:0]  nel;
        rc      = 2'(e);
        last_d  = (k == 1) ? sums[e] : ((e == 0) ? 17'd0 : sums[e-1]);
        last_rc = (k == 1) ? rc : ((e == 0) ? 2'd0 : 2'(e - 1));
        nel     = (k == 1) ? 3'(e + 1) : 3'(e);
        drive(1'b1, rc[1], k[0], rc[0], prods[2*e+k], 1'b0);
        chk($sformatf("gap_e%0d_k%0d", e, k),
            pack(k[0], last_rc[1], last_rc[0], last_d, (e == 3) && (k == 1), 1'b0, nel));
        for (int g = 0; g < 3; g++) begin
          drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
          chk($sformatf("gap_e%0d_k%0d_idle%0d", e, k, g),
              pack(1'b0, last_rc[1], last_rc[0], last_d, (e == 3) && (k == 1), 1'b0, nel));
        end
      end
    end

    // Repeated k=0 restarts the element; single write of 7+14.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 1'b0);
    chk("seq_first_k0", pack(1'b0, 1'b0, 1'b0, 17'd0, 1'b0, 1'b0, 3'd0));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd7, 1'b0);
    chk("seq_dup_k0", pack(1'b0, 1'b0, 1'b0, 17'd0, 1'b0, 1'b1, 3'd0));
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'd14, 1'b0);
    chk("seq_write_21", pack(1'b1, 1'b0, 1'b0, 17'd21, 1'b0, 1'b1, 3'd1));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("seq_we_one_cycle", pack(1'b0, 1'b0, 1'b0, 17'd21, 1'b0, 1'b1, 3'd1));

    // k=1 arriving in IDLE is ignored but flagged.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'd9, 1'b0);
    chk("idle_k1_err", pack(1'b0, 1'b0, 1'b0, 17'd0, 1'b0, 1'b1, 3'd0));
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'd6, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'd16, 1'b0);
    chk("idle_k1_then_ok", pack(1'b1, 1'b0, 1'b1, 17'd22, 1'b0, 1'b1, 3'd1));

    // Widest products: 255*255 twice must not truncate.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd65025, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'd65025, 1'b0);
    chk("max_sum", pack(1'b1, 1'b0, 1'b0, 17'd130050, 1'b0, 1'b0, 3'd1));

    // Reset mid-element drops the partial sum.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'd6, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'd16, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 1'b0);
    resetn = 1'b0;
    #2;
    chk("mid_reset_outputs", 25'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'd14, 1'b0);
    chk("mid_reset_resume", pack(1'b1, 1'b0, 1'b0, 17'd19, 1'b0, 1'b0, 3'd1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_stop_accum.md
Name: mac_stop_accum

Overview:
- Accumulation/write-back stage directly downstream of the MAC multiplier stage.
- Consumes the multiplier's registered product, its valid pulse and its registered (row, k, col) index tags.
- Sums K consecutive products into one result element, then writes it to result matrix C through a simple write port.
- Flags completion of the full MxN result and any out-of-order k sequence.

Parameters:
M, 2, rows of A / rows of C (>=2)
K, 2, inner dimension, products per result element (>=2)
N, 2, columns of B / columns of C (>=2)
DATA_WIDTH_INIT_MATRIX, 32, operand width feeding the multiplier
DATA_WIDTH_RESULT_MATRIX, 2*DATA_WIDTH_INIT_MATRIX+$clog2(K), result element width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
product_in  in  2*DATA_WIDTH_INIT_MATRIX  unsigned product from multiplier
product_valid  in  1  product_in and index tags valid this cycle
row_idx  in  $clog2(M)  A row / C row tag of product
k_idx  in  $clog2(K)  inner index tag of product
col_idx  in  $clog2(N)  B col / C col tag of product
clear_done  in  1  releases DONE state, returns to IDLE
result_we  out  1  one-cycle write strobe to C memory
result_row_addr  out  $clog2(M)  C row address
result_col_addr  out  $clog2(N)  C column address
result_data  out  DATA_WIDTH_RESULT_MATRIX  completed dot product
accum_done  out  1  high while in DONE
seq_err  out  1  sticky k-sequence error
elems_written  out  $clog2(M*N+1)  result elements written since IDLE

Behaviour:
- Reset (async, resetn low): state=IDLE, acc=0, expected_k=0, all outputs 0. Reset mid-element discards the partial sum; no write issued.
- States: IDLE, ACC, DONE.
- IDLE: product_valid with k_idx==0 -> acc<=zero-extended product_in, expected_k<=1, go ACC. Valid with k_idx!=0 -> ignored, seq_err<=1, stay IDLE.
- ACC, product_valid, k_idx==expected_k, k_idx<K-1: acc<=acc+product_in; expected_k++.
- ACC, product_valid, k_idx==K-1==expected_k: result_data<=acc+product_in, result_row_addr<=row_idx, result_col_addr<=col_idx, result_we<=1 next cycle (latency 1 from final product), acc<=0, expected_k<=0, elems_written++.
- After that write, if (row_idx,col_idx)==(M-1,N-1) -> DONE; otherwise the state advances to IDLE-equivalent (k=0 expected), staying in ACC with expected_k=0.
- ACC, product_valid, k_idx!=expected_k: seq_err<=1 (sticky until reset), acc restarts: if k_idx==0 acc<=product_in, expected_k<=1; else acc<=0, expected_k<=0. No write for the corrupted element.
- No product_valid: hold acc, expected_k; gaps of any length allowed between products.
- result_we is high for exactly one cycle per element. result_data and addresses hold their last values between strobes.
- DONE: accum_done=1; product_valid ignored (no accumulation, no write). clear_done -> IDLE next cycle: elems_written<=0, accum_done<=0. seq_err is not cleared.
- clear_done outside DONE: no effect.
- Arithmetic: unsigned. product zero-extended to result width; K products never overflow DATA_WIDTH_RESULT_MATRIX.
- Tags are taken from the final (k=K-1) product only; row/col of earlier products are not checked.

Decomposition:
- Shared package mac_stop_pkg: state enum typedef (IDLE/ACC/DONE); index-width localparams derived from M/K/N; result-width function.
- Sub-module mac_stop_acc_reg: accumulator register with load/add/clear controls and the final-sum output register.
- FSM, sequence check and write port stay in the top.

Test Plan:
- M=K=N=2, DW=8, products for C=[[1,2],[3,4]]x[[5,6],[7,8]] fed back-to-back (5,14 | 6,16 | 15,28 | 18,32) -> writes (0,0)=19, (0,1)=22, (1,0)=43, (1,1)=50; each result_we 1 cycle after k=1 product; accum_done=1 after the 4th write; elems_written=4.
- Same stream with 3 idle cycles inserted between every product -> identical writes and data, no seq_err.
- k_idx sequence 0,0,1 for element (0,0) with products 5,7,14 -> seq_err=1; single write (0,0)=21.
- Products 255*255 twice, DW=8, K=2 -> result_data=130050, no truncation.
- In DONE, inject product_valid -> no result_we. Pulse clear_done -> IDLE, accum_done=0, elems_written=0; a new stream accumulates correctly.
- resetn low after the k=0 product of element (0,0) -> all outputs 0. Resumed stream from k=0 yields the correct 19 with no stale sum.
